// File: rtl/fetch_byte_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : FetchQueuePkg
//  Description : Shared sizing constants, types and pointer helper for the
//                fetch byte queue.
//  Revision    : 1.0 - initial release
// ============================================================================
package FetchQueuePkg;

   localparam int unsigned FQ_LINE_BYTES  = 64;
   localparam int unsigned FQ_WIN_BYTES   = 15;
   localparam int unsigned FQ_DEPTH_BYTES = 128;

   typedef logic [$clog2(FQ_DEPTH_BYTES)-1:0] fq_ptr_t;
   typedef logic [$clog2(FQ_DEPTH_BYTES):0]   fq_cnt_t;

   // Depth is a power of two, so wrapping is a simple mask.
   function automatic int unsigned fq_wrap(
      input int unsigned ptr,
      input int unsigned add,
      input int unsigned depth = FQ_DEPTH_BYTES
   );
      return (ptr + add) & (depth - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_byte_queue_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_byte_queue_if
//  Description : Line-enqueue / decoder-window bundle for the fetch byte
//                queue. FETCH_QUEUE_STATS_EN adds the statistics outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_byte_queue_if import FetchQueuePkg::*; #(
   parameter int unsigned LINE_BYTES  = FQ_LINE_BYTES,
   parameter int unsigned WIN_BYTES   = FQ_WIN_BYTES,
   parameter int unsigned DEPTH_BYTES = FQ_DEPTH_BYTES
) ();

   logic                           flush;
   logic                           enq_valid;
   logic [$clog2(LINE_BYTES)-1:0]  enq_offset;
   logic [LINE_BYTES*8-1:0]        enq_line;
   logic [$clog2(WIN_BYTES):0]     deq_cnt;
   logic [WIN_BYTES*8-1:0]         win_data;
   logic                           win_full;
   logic [$clog2(DEPTH_BYTES):0]   used_cnt;
   logic [$clog2(DEPTH_BYTES):0]   empty_cnt;
   logic                           line_room;
   logic                           overflow;
   logic                           underflow;
`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0]                    stat_starve_cycles;
   logic [31:0]                    stat_bytes_out;
`endif

   modport master (
      output flush, enq_valid, enq_offset, enq_line, deq_cnt,
      input  win_data, win_full, used_cnt, empty_cnt, line_room, overflow, underflow
`ifdef FETCH_QUEUE_STATS_EN
      , input stat_starve_cycles, stat_bytes_out
`endif
   );

   modport slave (
      input  flush, enq_valid, enq_offset, enq_line, deq_cnt,
      output win_data, win_full, used_cnt, empty_cnt, line_room, overflow, underflow
`ifdef FETCH_QUEUE_STATS_EN
      , output stat_starve_cycles, stat_bytes_out
`endif
   );

endinterface
`default_nettype wire

// File: rtl/fetch_byte_queue_rotator.sv
`default_nettype none
// ============================================================================
//  Module      : fq_window_rotator
//  Description : Combinational rotate/mask of the byte store into the
//                decoder window starting at the head pointer.
//  Revision    : 1.0 - initial release
// ============================================================================
module fq_window_rotator import FetchQueuePkg::*; #(
   parameter int unsigned WIN_BYTES   = FQ_WIN_BYTES,
   parameter int unsigned DEPTH_BYTES = FQ_DEPTH_BYTES
) (
   input  wire logic [DEPTH_BYTES*8-1:0]          i_mem,
   input  wire logic [$clog2(DEPTH_BYTES)-1:0]    i_head,
   input  wire logic [$clog2(DEPTH_BYTES):0]      i_count,
   output logic      [WIN_BYTES*8-1:0]            o_win_data
);

   localparam int unsigned c_PTR_W = $clog2(DEPTH_BYTES);
   localparam int unsigned c_CNT_W = c_PTR_W + 1;

   for (genvar i = 0; i < WIN_BYTES; i++) begin : g_win
      localparam logic [c_CNT_W-1:0] c_I = c_CNT_W'(i);
      logic [c_PTR_W-1:0] w_idx;

      assign w_idx = c_PTR_W'(fq_wrap(32'(i_head), 32'(i), DEPTH_BYTES));
      // Bytes beyond the occupancy read as zero, never as stale storage.
      assign o_win_data[i*8 +: 8] = (c_I < i_count) ? i_mem[{w_idx, 3'b000} +: 8] : 8'h00;
   end

endmodule
`default_nettype wire

// File: rtl/fetch_byte_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_byte_queue
//  Description : Byte-granular circular buffer between line reader and x86
//                decoder. Optional macro FETCH_QUEUE_STATS_EN adds
//                saturating starve/bytes-out counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_byte_queue import FetchQueuePkg::*; #(
   parameter int unsigned LINE_BYTES  = FQ_LINE_BYTES,
   parameter int unsigned WIN_BYTES   = FQ_WIN_BYTES,
   parameter int unsigned DEPTH_BYTES = FQ_DEPTH_BYTES
) (
   input wire logic           clk,
   input wire logic           reset,
   fetch_byte_queue_if.slave  bus
);

   localparam int unsigned c_PTR_W = $clog2(DEPTH_BYTES);
   localparam int unsigned c_CNT_W = c_PTR_W + 1;
   localparam int unsigned c_OFF_W = $clog2(LINE_BYTES);

   logic [c_PTR_W-1:0]        r_head;
   logic [c_PTR_W-1:0]        r_tail;
   logic [c_CNT_W-1:0]        r_count;
   logic                      r_overflow;
   logic                      r_underflow;
   logic [DEPTH_BYTES*8-1:0]  w_mem_flat;
   logic [c_CNT_W-1:0]        w_empty;
   logic [c_CNT_W-1:0]        w_enq_len;
   logic [c_CNT_W-1:0]        w_enq_add;
   logic [c_CNT_W-1:0]        w_deq_req;
   logic [c_CNT_W-1:0]        w_eff_deq;
   logic                      w_enq_try;
   logic                      w_enq_ok;
   logic                      w_deq_over;
   logic                      w_win_full;

   // Acceptance uses pre-cycle room only; a same-cycle dequeue frees nothing.
   always_comb begin
      w_empty    = c_CNT_W'(DEPTH_BYTES) - r_count;
      w_enq_len  = c_CNT_W'(LINE_BYTES) - c_CNT_W'(bus.enq_offset);
      w_enq_try  = bus.enq_valid && !bus.flush;
      w_enq_ok   = w_enq_try && (w_enq_len <= w_empty);
      w_enq_add  = w_enq_ok ? w_enq_len : '0;
      w_deq_req  = c_CNT_W'(bus.deq_cnt);
      w_deq_over = !bus.flush && (w_deq_req > r_count);
      w_eff_deq  = bus.flush ? '0 : (w_deq_over ? r_count : w_deq_req);
      w_win_full = r_count >= c_CNT_W'(WIN_BYTES);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (bus.flush) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head  <= c_PTR_W'(fq_wrap(32'(r_head), 32'(w_eff_deq), DEPTH_BYTES));
         r_tail  <= c_PTR_W'(fq_wrap(32'(r_tail), 32'(w_enq_add), DEPTH_BYTES));
         r_count <= r_count + w_enq_add - w_eff_deq;
         if (w_enq_try && !w_enq_ok) r_overflow  <= 1'b1;
         if (w_deq_over)             r_underflow <= 1'b1;
      end
   end

   // Each storage byte picks its source from its distance past the tail.
   for (genvar k = 0; k < DEPTH_BYTES; k++) begin : g_mem
      localparam logic [c_PTR_W-1:0] c_K = c_PTR_W'(k);
      logic [c_PTR_W-1:0] w_rel;
      logic [c_OFF_W-1:0] w_src;
      logic               w_hit;
      logic [7:0]         r_byte;

      assign w_rel = c_K - r_tail;
      assign w_hit = w_enq_ok && (c_CNT_W'(w_rel) < w_enq_len);
      assign w_src = c_OFF_W'(c_PTR_W'(bus.enq_offset) + w_rel);

      always_ff @(posedge clk) begin
         if (w_hit) r_byte <= bus.enq_line[{w_src, 3'b000} +: 8];
      end

      assign w_mem_flat[k*8 +: 8] = r_byte;
   end

   fq_window_rotator #(
      .WIN_BYTES   (WIN_BYTES),
      .DEPTH_BYTES (DEPTH_BYTES)
   ) u_rotator (
      .i_mem      (w_mem_flat),
      .i_head     (r_head),
      .i_count    (r_count),
      .o_win_data (bus.win_data)
   );

   assign bus.win_full  = w_win_full;
   assign bus.used_cnt  = r_count;
   assign bus.empty_cnt = w_empty;
   assign bus.line_room = w_empty >= c_CNT_W'(LINE_BYTES);
   assign bus.overflow  = r_overflow;
   assign bus.underflow = r_underflow;

`ifdef FETCH_QUEUE_STATS_EN
   logic [31:0] r_stat_starve;
   logic [31:0] r_stat_bytes;
   logic [32:0] w_bytes_sum;

   assign w_bytes_sum = {1'b0, r_stat_bytes} + 33'(w_eff_deq);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_stat_starve <= '0;
         r_stat_bytes  <= '0;
      end else begin
         if (!w_win_full && !bus.flush && (r_stat_starve != 32'hFFFF_FFFF))
            r_stat_starve <= r_stat_starve + 32'd1;
         r_stat_bytes <= w_bytes_sum[32] ? 32'hFFFF_FFFF : w_bytes_sum[31:0];
      end
   end

   assign bus.stat_starve_cycles = r_stat_starve;
   assign bus.stat_bytes_out     = r_stat_bytes;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_byte_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_byte_queue
//  Description : Vector-table bench with a byte-queue scoreboard for the
//                fetch byte queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_byte_queue;
   import FetchQueuePkg::*;

   localparam int unsigned c_LINE  = FQ_LINE_BYTES;
   localparam int unsigned c_WIN   = FQ_WIN_BYTES;
   localparam int unsigned c_DEPTH = FQ_DEPTH_BYTES;

   logic clk = 1'b0;
   logic reset;

   fetch_byte_queue_if bus ();

   fetch_byte_queue dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          flush;
      bit          enq;
      int unsigned off;
      int unsigned deq;
      int unsigned base;
      int unsigned used;
      bit          ovf;
      bit          unf;
   } vec_t;

   vec_t             vecs[$];
   byte unsigned     sb[$];
   int unsigned      n_checks = 0;
   int unsigned      n_fail   = 0;
   longint unsigned  m_starve = 0;
   longint unsigned  m_bytes  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   function automatic void add(input bit fl, input bit en, input int unsigned off,
                               input int unsigned deq, input int unsigned base,
                               input int unsigned used, input bit ovf, input bit unf);
      vec_t v;
      v.flush = fl; v.enq = en; v.off = off; v.deq = deq; v.base = base;
      v.used = used; v.ovf = ovf; v.unf = unf;
      vecs.push_back(v);
   endfunction

   function automatic logic [c_WIN*8-1:0] exp_window();
      logic [c_WIN*8-1:0] w = '0;
      for (int i = 0; i < c_WIN; i++)
         if (i < sb.size()) w[i*8 +: 8] = sb[i];
      return w;
   endfunction

   task automatic check_all(input string tag, input int unsigned used, input bit ovf, input bit unf);
      chk({tag, "_used"},  bus.used_cnt,  used);
      chk({tag, "_sbused"}, bus.used_cnt, sb.size());
      chk({tag, "_empty"}, bus.empty_cnt, c_DEPTH - used);
      chk({tag, "_wfull"}, bus.win_full,  used >= c_WIN);
      chk({tag, "_room"},  bus.line_room, (c_DEPTH - used) >= c_LINE);
      chk({tag, "_ovf"},   bus.overflow,  ovf);
      chk({tag, "_unf"},   bus.underflow, unf);
      chk({tag, "_win"},   bus.win_data,  exp_window());
`ifdef FETCH_QUEUE_STATS_EN
      chk({tag, "_starve"}, bus.stat_starve_cycles, m_starve);
      chk({tag, "_bytes"},  bus.stat_bytes_out,     m_bytes);
`endif
   endtask

   task automatic step(input vec_t v);
      logic [c_LINE*8-1:0] line;
      int unsigned         pre;
      int unsigned         eff;
      for (int j = 0; j < c_LINE; j++) line[j*8 +: 8] = 8'(v.base + j);
      bus.flush      = v.flush;
      bus.enq_valid  = v.enq;
      bus.enq_offset = 6'(v.off);
      bus.enq_line   = line;
      bus.deq_cnt    = 5'(v.deq);
      pre = sb.size();
      if (v.flush) begin
         sb.delete();
      end else begin
         if (pre < c_WIN) m_starve++;
         eff = (v.deq > pre) ? pre : v.deq;
         m_bytes += eff;
         if (v.enq && ((c_LINE - v.off) <= (c_DEPTH - pre)))
            for (int j = v.off; j < c_LINE; j++) sb.push_back(8'(v.base + j));
         for (int j = 0; j < eff; j++) void'(sb.pop_front());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t idle;
      idle = '{flush: 1'b0, enq: 1'b0, off: 0, deq: 0, base: 0, used: 0, ovf: 1'b0, unf: 1'b0};

      //   flush enq off   deq base  used ovf unf
      add(0, 1, 0,    0,  8'h00, 64,  0, 0);
      add(1, 0, 0,    0,  0,     0,   0, 0);
      add(0, 1, 8'h3A,0,  8'h00, 6,   0, 0);
      add(0, 1, 0,    0,  8'h40, 70,  0, 0);
      add(0, 1, 0,    15, 8'h80, 55,  1, 0);
      add(0, 1, 0,    0,  8'hC0, 119, 1, 0);
      for (int i = 0; i < 7; i++) add(0, 0, 0, 15, 0, 104 - 15*i, 1, 0);
      add(0, 1, 0,    0,  8'h10, 78,  1, 0);
      add(0, 1, 14,   0,  8'h50, 128, 1, 0);
      add(0, 0, 0,    15, 0,     113, 1, 0);
      add(0, 0, 0,    15, 0,     98,  1, 0);
      add(0, 0, 0,    3,  0,     95,  1, 0);
      add(0, 1, 0,    0,  8'h20, 95,  1, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 15, 0, 80 - 15*i, 1, 0);
      add(0, 0, 0,    2,  0,     3,   1, 0);
      add(0, 0, 0,    5,  0,     0,   1, 1);
      add(1, 1, 0,    0,  8'h30, 0,   1, 1);
      add(0, 1, 24,   0,  8'h60, 40,  1, 1);
      add(0, 1, 40,   10, 8'hA0, 54,  1, 1);
      add(0, 0, 0,    14, 0,     40,  1, 1);

      bus.flush = 1'b0; bus.enq_valid = 1'b0; bus.enq_offset = '0;
      bus.enq_line = '0; bus.deq_cnt = '0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_all("reset", 0, 0, 0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i]);
         check_all($sformatf("v%0d", i), vecs[i].used, vecs[i].ovf, vecs[i].unf);
      end

      // Asynchronous reset while 40 bytes are held, sampled before any edge.
      bus.flush = 1'b0; bus.enq_valid = 1'b0; bus.deq_cnt = '0;
      #2;
      reset = 1'b0;
      #1;
      sb.delete();
      m_starve = 0;
      m_bytes  = 0;
      check_all("async_rst", 0, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      idle.enq  = 1'b1;
      idle.base = 8'h77;
      step(idle);
      check_all("post_rst", 64, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
